spi_shift_engine: RTL

- Byte-wide SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits directly downstream of the AHB SPI register adapter and consumes its start pulse, write byte and chip-select level.
- Returns busy status and the received byte to the adapter's READY/DATA read path.
- Drives SCLK/MOSI and samples MISO on the board pins.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_shift_engine_if.sv | 22 ++
 rtl/spi_clk_div.sv | 33 +++
 rtl/spi_shift_engine.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 shift engine.
// Build option SPI_LSB_FIRST_EN (see spi_shift_engine.sv) selects LSB-first shifting.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 4;

    function automatic int bit_cnt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

    localparam int BIT_CNT_W = bit_cnt_w(DEF_DATA_W);

endpackage

// File: rtl/spi_shift_engine_if.sv
// Adapter-side bus of the SPI shift engine: start/data/chip-select in, busy/data out.
interface spi_shift_engine_if
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              start_i;
    logic [DATA_W-1:0] data_in_bi;
    logic              spi_cs_i;
    logic              busy_o;
    logic [DATA_W-1:0] data_out_bo;

    modport master (
        output start_i, data_in_bi, spi_cs_i,
        input  busy_o, data_out_bo
    );

    modport slave (
        input  start_i, data_in_bi, spi_cs_i,
        output busy_o, data_out_bo
    );
endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: one-cycle half_tick every CLK_DIV enabled cycles.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic restart_i,
    output logic half_tick_o
);
    localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign half_tick_o = en_i && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (!en_i || restart_i || half_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_shift_engine.sv
// Byte-wide SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first by default.
// Define SPI_LSB_FIRST_EN to shift LSB first in both directions; timing is unchanged.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    spi_shift_engine_if.slave   bus,
    input  logic                spi_miso_i,
    output logic                spi_mosi_o,
    output logic                spi_sclk_o
);
    localparam int                CNT_W    = bit_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SPI_LSB_FIRST_EN
    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
        return v >> 1;
    endfunction
    function automatic logic tx_bit(input logic [DATA_W-1:0] v);
        return v[0];
    endfunction
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b);
        return {b, v[DATA_W-1:1]};
    endfunction
`else
    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] v);
        return v << 1;
    endfunction
    function automatic logic tx_bit(input logic [DATA_W-1:0] v);
        return v[DATA_W-1];
    endfunction
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] v, input logic b);
        return {v[DATA_W-2:0], b};
    endfunction
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic              accept;
    logic              half_tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (state_q != IDLE),
        .restart_i   (accept),
        .half_tick_o (half_tick)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        accept  = 1'b0;

        // Chip-select release aborts any transfer without touching the result.
        if (state_q != IDLE && bus.spi_cs_i) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            mosi_d  = 1'b0;
            sclk_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i && !bus.spi_cs_i) begin
                        accept  = 1'b1;
                        tx_d    = bus.data_in_bi;
                        busy_d  = 1'b1;
                        mosi_d  = tx_bit(bus.data_in_bi);
                        cnt_d   = '0;
                        state_d = SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (half_tick) begin
                        sclk_d  = 1'b1;
                        rx_d    = rx_shift(rx_q, spi_miso_i);
                        state_d = SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (half_tick) begin
                        sclk_d = 1'b0;
                        if (cnt_q < LAST_BIT) begin
                            cnt_d   = cnt_q + 1'b1;
                            tx_d    = tx_shift(tx_q);
                            mosi_d  = tx_bit(tx_shift(tx_q));
                            state_d = SHIFT_LO;
                        end else begin
                            dout_d  = rx_q;
                            busy_d  = 1'b0;
                            mosi_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                    sclk_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.data_out_bo = dout_q;
    assign spi_mosi_o      = mosi_q;
    assign spi_sclk_o      = sclk_q;
endmodule
